// File: rtl/sram_ctl_pkg.sv
// sram_ctl_pkg
// Shared definitions for the asynchronous SRAM initiator: FSM state
// encoding (3-bit) and the wait-counter width plus its load helper.
// No ports (package).
package sram_ctl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_TURN   = 3'd2,
    ST_WSETUP = 3'd3,
    ST_WPULSE = 3'd4,
    ST_WHOLD  = 3'd5
  } state_e;

  // Load value for a phase lasting 'cycles' clocks; the counter runs down to 0.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_ctl.sv
// sram_ctl
// Synchronous initiator for an asynchronous 8-bit static RAM. Converts
// single-beat valid/ready read/write requests into /CE, /OE, /WE strobe
// cycles with parameterised wait states. All pin-facing outputs are
// registered from the next state, so strobes are glitch-free.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   req_valid  request present
//   req_ready  controller idle; accept on req_valid && req_ready
//   req_we     1 = write, 0 = read
//   req_addr   request address
//   req_wdata  write data
//   rsp_valid  one-cycle pulse: read data valid or write finished
//   rsp_rdata  last read data, held until the next read completes
//   sram_a     RAM address
//   sram_d     RAM data (driven only in write states)
//   sram_nce / sram_noe / sram_nwe   active-low RAM strobes
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready, strobes high, bus released
// ST_READ   | /CE,/OE low, counting RD_WAIT; sample D when count hits 0
// ST_TURN   | one cycle all strobes high: bus turnaround after a read
// ST_WSETUP | /CE low, D driven, /WE high: address/data setup
// ST_WPULSE | /CE,/WE low, D driven, counting WR_WAIT
// ST_WHOLD  | /WE high again, /CE low, A and D held for hold time
module sram_ctl
  import sram_ctl_pkg::*;
#(
  parameter int ABITS   = 19,
  parameter int RD_WAIT = 3,
  parameter int WR_WAIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ABITS-1:0] req_addr,
  input  logic [7:0]       req_wdata,
  output logic             rsp_valid,
  output logic [7:0]       rsp_rdata,
  output logic [ABITS-1:0] sram_a,
  inout  wire  [7:0]       sram_d,
  output logic             sram_nce,
  output logic             sram_noe,
  output logic             sram_nwe
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             nce_q, nce_d;
  logic             noe_q, noe_d;
  logic             nwe_q, nwe_d;
  logic             drive_q, drive_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_we) begin
            state_d = ST_WSETUP;
          end else begin
            state_d = ST_READ;
            cnt_d   = wait_load(RD_WAIT);
          end
        end
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          rdata_d     = sram_d;
          rsp_valid_d = 1'b1;
          state_d     = ST_TURN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_TURN: state_d = ST_IDLE;
      ST_WSETUP: begin
        state_d = ST_WPULSE;
        cnt_d   = wait_load(WR_WAIT);
      end
      ST_WPULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_WHOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WHOLD: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin outputs follow the state being entered, so they change on the
    // same edge as the state register and never glitch.
    ready_d = (state_d == ST_IDLE);
    nce_d   = (state_d == ST_IDLE) || (state_d == ST_TURN);
    noe_d   = (state_d != ST_READ);
    nwe_d   = (state_d != ST_WPULSE);
    drive_d = (state_d == ST_WSETUP) || (state_d == ST_WPULSE) ||
              (state_d == ST_WHOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      nce_q       <= 1'b1;
      noe_q       <= 1'b1;
      nwe_q       <= 1'b1;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      nce_q       <= nce_d;
      noe_q       <= noe_d;
      nwe_q       <= nwe_d;
      drive_q     <= drive_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign sram_a    = addr_q;
  assign sram_nce  = nce_q;
  assign sram_noe  = noe_q;
  assign sram_nwe  = nwe_q;
  assign sram_d    = drive_q ? wdata_q : 8'bz;

endmodule

// File: tb/tb_sram_ctl.sv
// Self-checking bench for sram_ctl: behavioural RAM on the pins, a
// reference memory plus latency rules producing expected responses, and
// a monitor that pops and compares on every rsp_valid.
module tb_sram_ctl;

  localparam int         AB       = 19;
  localparam int         RD_LAT   = 3 + 1;  // accept edge -> rsp_valid cycle
  localparam int         WR_LAT   = 3 + 3;
  localparam logic [7:0] SENTINEL = 8'h0F;
  localparam logic [7:0] PROBE    = 8'h96;

  // ---------------- default-parameter instance (20 ns clock) -------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          reset, req_valid, req_ready, req_we, rsp_valid;
  logic [AB-1:0] req_addr, sram_a;
  logic [7:0]    req_wdata, rsp_rdata;
  logic          sram_nce, sram_noe, sram_nwe;
  logic          probe_en;
  wire  [7:0]    sram_d;

  sram_ctl #(.ABITS(AB), .RD_WAIT(3), .WR_WAIT(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sram_a(sram_a),
    .sram_d(sram_d), .sram_nce(sram_nce), .sram_noe(sram_noe),
    .sram_nwe(sram_nwe)
  );

  logic [7:0] ram [logic [AB-1:0]];
  function automatic logic [7:0] ram_rd(input logic [AB-1:0] a);
    return ram.exists(a) ? ram[a] : SENTINEL;
  endfunction
  assign sram_d = (!sram_nce && !sram_noe) ? ram_rd(sram_a) : 8'bz;
  // Probe driver: if the controller still drives D, the resolved value differs.
  assign sram_d = probe_en ? PROBE : 8'bz;
  always @(posedge sram_nwe) if (!sram_nce) ram[sram_a] = sram_d;

  // ---------------- sweep instance: RD_WAIT=WR_WAIT=1, 100 ns clock -------
  logic clk1 = 1'b0;
  always #50 clk1 = ~clk1;

  logic          s_reset, s_valid, s_ready, s_we, s_rsp_valid;
  logic [AB-1:0] s_addr, s_a;
  logic [7:0]    s_wdata, s_rdata;
  logic          s_nce, s_noe, s_nwe;
  wire  [7:0]    s_d;

  sram_ctl #(.ABITS(AB), .RD_WAIT(1), .WR_WAIT(1)) dut_sw (
    .clk(clk1), .reset(s_reset), .req_valid(s_valid), .req_ready(s_ready),
    .req_we(s_we), .req_addr(s_addr), .req_wdata(s_wdata),
    .rsp_valid(s_rsp_valid), .rsp_rdata(s_rdata), .sram_a(s_a),
    .sram_d(s_d), .sram_nce(s_nce), .sram_noe(s_noe), .sram_nwe(s_nwe)
  );

  logic [7:0] ram1 [logic [AB-1:0]];
  function automatic logic [7:0] ram1_rd(input logic [AB-1:0] a);
    return ram1.exists(a) ? ram1[a] : SENTINEL;
  endfunction
  assign s_d = (!s_nce && !s_noe) ? ram1_rd(s_a) : 8'bz;
  always @(posedge s_nwe) if (!s_nce) ram1[s_a] = s_d;

  // ---------------- reference model and scoreboard ------------------------
  logic [7:0] ref_mem [logic [AB-1:0]];
  function automatic logic [7:0] ref_rd(input logic [AB-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : SENTINEL;
  endfunction

  typedef struct {
    logic       is_wr;
    logic [7:0] data;
    int         acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   acc_log[$];
  int   compared = 0, mismatched = 0;
  int   cyc = 0, n_rsp = 0, last_lat = 0, nwe_lo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Accept capture: inputs are stable between negedge and the accepting edge.
  always @(negedge clk) begin
    if (!reset && req_valid && req_ready) begin
      acc_log.push_back(cyc);
      if (req_we) begin
        ref_mem[req_addr] = req_wdata;
        sb_q.push_back('{1'b1, 8'h00, cyc});
      end else begin
        sb_q.push_back('{1'b0, ref_rd(req_addr), cyc});
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      n_rsp++;
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rsp: rsp_valid at cycle %0d, none outstanding", cyc);
      end else begin
        mon_e    = sb_q.pop_front();
        last_lat = cyc - mon_e.acc_cyc;
        chk(mon_e.is_wr ? "wr_latency" : "rd_latency", 32'(last_lat),
            32'(mon_e.is_wr ? WR_LAT : RD_LAT));
        if (!mon_e.is_wr) chk("rd_data", {24'h0, rsp_rdata}, {24'h0, mon_e.data});
      end
    end
  end

  // Strobe/bus invariants.
  always @(negedge clk) begin
    if (!reset) begin
      if (!sram_nwe) nwe_lo++;
      compared++;
      if (!sram_noe && !sram_nwe) begin
        mismatched++;
        $display("FAIL oe_we_overlap: noe=%b nwe=%b at cycle %0d", sram_noe, sram_nwe, cyc);
      end
      if (!sram_noe) chk("d_contention", {24'h0, sram_d}, {24'h0, ram_rd(sram_a)});
    end
  end

  task automatic issue(input logic we, input logic [AB-1:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    compared++;
    mismatched++;
    $display("FAIL accept_timeout: req_ready stayed low for addr %0h", a);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && req_ready) return;
    end
    compared++;
    mismatched++;
    $display("FAIL idle_timeout: %0d responses outstanding", sb_q.size());
  endtask

  logic [2:0] sw_wr_exp [4] = '{3'b010, 3'b000, 3'b010, 3'b111};
  logic [1:0] sw_rd_exp [3] = '{2'b00, 2'b11, 2'b10};

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, r0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    probe_en = 1'b0;
    s_reset = 1'b1; s_valid = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", {24'h0, rsp_rdata}, 32'h00);
    chk("rst_addr", 32'(sram_a), 32'd0);
    chk("rst_strobes", {29'h0, sram_nce, sram_noe, sram_nwe}, 32'h7);
    probe_en = 1'b1;
    #1;
    chk("rst_d_released", {24'h0, sram_d}, {24'h0, PROBE});
    probe_en = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Write then read
    base = nwe_lo;
    issue(1'b1, 19'h12345, 8'hA5);
    req_valid = 1'b0;
    wait_idle();
    chk("wr_nwe_cycles", 32'(nwe_lo - base), 32'd3);
    issue(1'b0, 19'h12345, 8'h00);
    req_valid = 1'b0;
    wait_idle();
    chk("wr_rd_data", {24'h0, rsp_rdata}, 32'hA5);

    // Unwritten read
    issue(1'b0, 19'h00010, 8'h00);
    req_valid = 1'b0;
    wait_idle();
    chk("unwritten_data", {24'h0, rsp_rdata}, 32'h0F);
    chk("unwritten_latency", 32'(last_lat), 32'd4);

    // Random alternating traffic
    for (int i = 0; i < 200; i++) begin
      issue(1'($urandom_range(0, 1)), AB'(32'h100 + $urandom_range(0, 15)),
            8'($urandom));
      req_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

    // Held request: four reads with valid never dropped
    acc_log.delete();
    r0 = n_rsp;
    for (int k = 0; k < 4; k++) issue(1'b0, AB'(32'h100 + k), 8'h00);
    req_valid = 1'b0;
    wait_idle();
    chk("held_accepts", 32'(acc_log.size()), 32'd4);
    if (acc_log.size() == 4)
      for (int k = 1; k < 4; k++)
        chk($sformatf("held_spacing_%0d", k), 32'(acc_log[k] - acc_log[k-1]), 32'd5);
    chk("held_rsps", 32'(n_rsp - r0), 32'd4);

    // Reset in the middle of a write pulse
    r0 = n_rsp;
    issue(1'b1, 19'h00020, 8'h3C);
    req_valid = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_reset_in_pulse", {30'h0, sram_nce, sram_nwe}, 32'd0);
    reset = 1'b1;
    probe_en = 1'b1;
    #1;
    chk("rst_mid_strobes", {29'h0, sram_nce, sram_noe, sram_nwe}, 32'h7);
    chk("rst_mid_d_released", {24'h0, sram_d}, {24'h0, PROBE});
    probe_en = 1'b0;
    sb_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_mid_no_rsp", 32'(n_rsp - r0), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);

    // Parameter sweep instance
    @(posedge clk1);
    #1 s_reset = 1'b0;
    @(negedge clk1);
    chk("sw_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_we = 1'b1; s_addr = 19'h00005; s_wdata = 8'h5A;
    @(posedge clk1);
    #1 s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk1);
      chk($sformatf("sw_wr_cycle_%0d", k), {29'h0, s_nce, s_nwe, s_rsp_valid},
          {29'h0, sw_wr_exp[k]});
    end
    s_valid = 1'b1; s_we = 1'b0; s_addr = 19'h00005;
    @(posedge clk1);
    #1 s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk1);
      chk($sformatf("sw_rd_cycle_%0d", k), {30'h0, s_noe, s_rsp_valid},
          {30'h0, sw_rd_exp[k]});
      if (k == 1) chk("sw_rd_data", {24'h0, s_rdata}, 32'h5A);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
